fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction address width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pc_address  input  ADDR_W  current fetch address from the program counter.
REQ-006 SHALL have port flush  input  1  jump or branch taken this cycle; discard all in-flight instructions.
REQ-007 SHALL have port pc_hold  output  1  the program counter must not advance this cycle.
REQ-008 SHALL have port id_ready  input  1  decode accepts the presented instruction.
REQ-009 SHALL have port instr_valid  output  1  instr and instr_pc are valid.
REQ-010 SHALL have port instr  output  INSTR_W  fetched instruction word.
REQ-011 SHALL have port instr_pc  output  ADDR_W  address the instruction was fetched from.
REQ-012 SHALL have port prog_we  input  1  program-load write enable.
REQ-013 SHALL have port prog_addr  input  ADDR_W  program-load address.
REQ-014 SHALL have port prog_data  input  INSTR_W  program-load data.

Function
REQ-015 SHALL hold a 2^ADDR_W x INSTR_W instruction memory with a synchronous read, addressed by pc_address, and a synchronous write from the prog_* port.
REQ-016 SHALL return the old word when the read and prog_we target the same address on the same edge.
REQ-017 SHALL define issue = !reset && !flush && !pc_hold; on an issue edge, capture req_pc <= pc_address and req_valid <= 1, else req_valid <= 0.
REQ-018 SHALL push {rom data, req_pc} into a 2-entry FIFO on the edge after the issue edge, whenever req_valid = 1 and flush = 0.
REQ-019 SHALL drive instr, instr_pc and instr_valid from the FIFO head; instr_valid = (count != 0).
REQ-020 SHALL define pop = instr_valid && id_ready and remove the head on that edge; push and pop on the same edge leave count unchanged.
REQ-021 SHALL drive pc_hold combinationally: pc_hold = !flush && ((count + req_valid - pop) >= 2).
REQ-022 SHALL have a latency of 2 edges: pc_address sampled at edge E appears with instr_valid = 1 after edge E+1 when the FIFO was empty.
REQ-023 SHALL sustain one instruction per cycle with id_ready held at 1 and no flush.
REQ-024 SHALL never overflow; when the FIFO is full and req_valid = 1, the design cannot be in that state by construction of REQ-021.
REQ-025 SHALL give flush priority over push, pop and issue: on a flush edge, count <= 0 and req_valid <= 0, and no request is captured.
REQ-026 SHALL have instr_valid = 0 in the cycle after a flush edge.
REQ-027 SHALL issue the redirected pc_address (already loaded by the program counter) on the first edge after flush.
REQ-028 SHALL hold instr and instr_pc stable while instr_valid = 1 and id_ready = 0.

Reset
REQ-029 SHALL, while reset = 1, force count = 0, req_valid = 0, req_pc = 0, instr_valid = 0, instr = 0 (NOP), instr_pc = 0 and pc_hold = 0, without waiting for a clock edge.
REQ-030 SHALL discard all in-flight state on reset asserted mid-operation.
REQ-031 SHALL not clear memory contents on reset.
REQ-032 SHALL issue its first request on the first rising edge with reset = 0.

Structure
REQ-033 SHALL take ADDR_W, INSTR_W and NOP_INSTR (16'h0000) from the shared package cpu_pkg.
REQ-034 SHALL implement the memory as sub-module instr_rom (sync read, sync write, read-before-write); FIFO and control stay in fetch_stage.

Verification
REQ-035 SHALL cover: preload mem[0..7] = 16'hA000+i, release reset, id_ready = 1, PC incrementing -> instr_valid high after 2 edges, then instr = A000..A007 with instr_pc = 0..7, one per cycle, and pc_hold = 0 throughout.
REQ-036 SHALL cover: steady stream, then id_ready = 0 for 4 cycles -> pc_hold = 1 by the second stall cycle, instr/instr_pc frozen, and no word lost or duplicated after id_ready returns.
REQ-037 SHALL cover: flush at PC = 5 with the target 8'h80 loaded and mem[80] = 16'hBEEF -> instr_valid = 0 the next cycle, then instr = BEEF with instr_pc = 80, and no word from address 5 or 6 delivered.
REQ-038 SHALL cover: flush with id_ready = 0 and the FIFO full -> count = 0 after the edge, and pc_hold = 0 during the flush cycle.
REQ-039 SHALL cover: reset asserted asynchronously mid-stream -> all outputs 0 immediately, and after release the fetch restarts at pc_address 0.
REQ-040 SHALL cover: prog_we to address 3 in the same cycle as the fetch of address 3 -> old word delivered, and the new word delivered on the next fetch of address 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: default datapath widths and the NOP encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: PC/flush/hold control, decode handshake and program-load port.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
);

  logic [ADDR_W-1:0]  pc_address;
  logic               flush;
  logic               pc_hold;
  logic               id_ready;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;

  // Core/loader side: drives PC, flush, decode-ready and program writes
  modport master (
    output pc_address, flush, id_ready, prog_we, prog_addr, prog_data,
    input  pc_hold, instr_valid, instr, instr_pc
  );

  // Fetch-stage side
  modport slave (
    input  pc_address, flush, id_ready, prog_we, prog_addr, prog_data,
    output pc_hold, instr_valid, instr, instr_pc
  );

endinterface

// File: rtl/fetch_stage_instr_rom.sv
// Instruction memory: synchronous read with enable, synchronous write; a same-edge
// read of the written address returns the old word. Contents survive reset.
module instr_rom #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               i_rd_en,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [INSTR_W-1:0] o_rd_data,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [INSTR_W-1:0] i_wr_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [INSTR_W-1:0] r_mem [DEPTH];

  // Both ports sample the array before this edge's write lands
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one request register feeding a 2-entry skid FIFO in front of
// decode. pc_hold back-pressures the PC so the FIFO can never overflow.
module fetch_stage #(
  parameter int unsigned ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned OCC_W      = 3;

  logic                  r_req_valid;
  logic [ADDR_W-1:0]     r_req_pc;
  logic [INSTR_W-1:0]    r_fifo_instr [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_fifo_pc    [FIFO_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic [INSTR_W-1:0]    w_rom_data;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_hold;
  logic                  w_issue;
  logic [OCC_W-1:0]      w_occ;

  // Occupancy after this edge decides whether a new request still fits
  always_comb begin
    w_pop   = (r_count != CNT_W'(0)) && bus.id_ready;
    w_push  = r_req_valid && !bus.flush;
    w_occ   = OCC_W'(r_count) + OCC_W'(r_req_valid) - OCC_W'(w_pop);
    w_hold  = !bus.flush && (w_occ >= OCC_W'(2));
    w_issue = !reset && !bus.flush && !w_hold;
  end

  instr_rom #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_rom (
    .clk       (clk),
    .i_rd_en   (w_issue),
    .i_rd_addr (bus.pc_address),
    .o_rd_data (w_rom_data),
    .i_we      (bus.prog_we),
    .i_wr_addr (bus.prog_addr),
    .i_wr_data (bus.prog_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= bus.pc_address;
      end
    end
  end

  // Flush outranks push and pop; stale entries are left behind but never valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_instr[i] <= INSTR_W'(cpu_pkg::NOP_INSTR);
        r_fifo_pc[i]    <= '0;
      end
    end else if (bus.flush) begin
      r_count  <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) begin
        r_fifo_instr[r_wr_ptr] <= w_rom_data;
        r_fifo_pc[r_wr_ptr]    <= r_req_pc;
        r_wr_ptr               <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.pc_hold     = w_hold;
  assign bus.instr_valid = (r_count != CNT_W'(0));
  assign bus.instr       = r_fifo_instr[r_rd_ptr];
  assign bus.instr_pc    = r_fifo_pc[r_rd_ptr];

endmodule
